// File: rtl/shift_seq_pkg.sv
// Shared definitions for the shift sequencer: FSM state encodings and
// pattern-mode codes. Imported by shift_seq_ctrl.
package shift_seq_pkg;

  // Sequencer states; encodings are fixed (IDLE=0 ... DONE=4).
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_SHIFT = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Serial-input pattern selection.
  typedef enum logic [1:0] {
    MODE_RING    = 2'd0,
    MODE_JOHNSON = 2'd1,
    MODE_FILL    = 2'd2,
    MODE_EXT     = 2'd3
  } mode_e;

endpackage

// File: rtl/shift_reg_ld.sv
// Loadable left-shift register: parallel load has priority over shift.
// Ports:
//   cp       - clock (rising edge)
//   reset    - synchronous active-high reset, contents go to RST_VAL
//   load     - load load_val at the next edge
//   shift_en - shift left by one, ser_in entering at bit 0
//   load_val - parallel load value
//   ser_in   - serial input
//   q        - registered contents
module shift_reg_ld #(
  parameter int unsigned WIDTH = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             cp,
  input  logic             reset,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] load_val,
  input  logic             ser_in,
  output logic [WIDTH-1:0] q
);

  // Contents register
  always_ff @(posedge cp) begin
    if (reset) begin
      q <= RST_VAL;
    end else if (load) begin
      q <= load_val;
    end else if (shift_en) begin
      q <= {q[WIDTH-2:0], ser_in};
    end
  end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Pattern shift sequencer: on start, latches mode/len/div, seeds the shift
// register and performs len shifts (optionally spaced by div idle cycles),
// then pulses done. stop aborts a run without loading or shifting.
// Optional feature: define SHIFT_SEQ_PRESCALE_EN to enable the WAIT state
// and the div prescaler; otherwise div is ignored and shifts are back to back.
// Ports:
//   cp, reset    - clock and synchronous active-high reset
//   start, stop  - run request (IDLE only) / abort request (non-IDLE)
//   mode         - 0 ring, 1 Johnson, 2 fill-ones, 3 external serial
//   len, div     - shifts per run / idle cycles between shifts
//   ext_x        - serial input for mode 3
//   out          - shift register contents
//   busy, done   - registered status: not IDLE / one-cycle DONE pulse
//   shift_pulse  - high in a cycle whose closing edge shifts (state-decoded)
module shift_seq_ctrl
  import shift_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 4
) (
  input  logic             cp,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] len,
  input  logic [CNT_W-1:0] div,
  input  logic             ext_x,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             done,
  output logic             shift_pulse
);

  localparam logic [WIDTH-1:0] MSB_ONE = {1'b1, {(WIDTH-1){1'b0}}};

  state_e           state, state_n;
  mode_e            mode_q;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] step_cnt, step_cnt_n;
  logic             latch_en, load_en, shift_en, ser_x;
  logic [WIDTH-1:0] seed;

`ifdef SHIFT_SEQ_PRESCALE_EN
  logic [CNT_W-1:0] div_q;
  logic [CNT_W-1:0] pre_cnt, pre_cnt_n;
`else
  logic unused_div;
  assign unused_div = ^div;
`endif

  // State, counters, latched run parameters and registered status
  always_ff @(posedge cp) begin
    if (reset) begin
      state    <= ST_IDLE;
      mode_q   <= MODE_RING;
      len_q    <= '0;
      step_cnt <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef SHIFT_SEQ_PRESCALE_EN
      div_q    <= '0;
      pre_cnt  <= '0;
`endif
    end else begin
      state    <= state_n;
      step_cnt <= step_cnt_n;
      busy     <= (state_n != ST_IDLE);
      done     <= (state_n == ST_DONE);
`ifdef SHIFT_SEQ_PRESCALE_EN
      pre_cnt  <= pre_cnt_n;
`endif
      if (latch_en) begin
        mode_q <= mode_e'(mode);
        len_q  <= len;
`ifdef SHIFT_SEQ_PRESCALE_EN
        div_q  <= div;
`endif
      end
    end
  end

  // Next-state, counter and datapath-control logic; stop overrides everything
  always_comb begin
    state_n    = state;
    step_cnt_n = step_cnt;
    latch_en   = 1'b0;
    load_en    = 1'b0;
    shift_en   = 1'b0;
`ifdef SHIFT_SEQ_PRESCALE_EN
    pre_cnt_n  = pre_cnt;
`endif
    if ((state != ST_IDLE) && stop) begin
      state_n = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: begin
          step_cnt_n = '0;
`ifdef SHIFT_SEQ_PRESCALE_EN
          pre_cnt_n  = '0;
`endif
          if (start) begin
            latch_en = 1'b1;
            state_n  = ST_LOAD;
          end
        end
        ST_LOAD: begin
          load_en = 1'b1;
          if (len_q == '0) begin
            state_n = ST_DONE;
          end else begin
`ifdef SHIFT_SEQ_PRESCALE_EN
            state_n = (div_q != '0) ? ST_WAIT : ST_SHIFT;
`else
            state_n = ST_SHIFT;
`endif
          end
        end
        ST_WAIT: begin
`ifdef SHIFT_SEQ_PRESCALE_EN
          if (CNT_W'(pre_cnt + CNT_W'(1)) == div_q) begin
            pre_cnt_n = '0;
            state_n   = ST_SHIFT;
          end else begin
            pre_cnt_n = pre_cnt + CNT_W'(1);
          end
`else
          state_n = ST_IDLE;
`endif
        end
        ST_SHIFT: begin
          shift_en   = 1'b1;
          step_cnt_n = step_cnt + CNT_W'(1);
          if (step_cnt_n == len_q) begin
            state_n = ST_DONE;
          end else begin
`ifdef SHIFT_SEQ_PRESCALE_EN
            state_n = (div_q != '0) ? ST_WAIT : ST_SHIFT;
`else
            state_n = ST_SHIFT;
`endif
          end
        end
        ST_DONE: begin
          state_n = ST_IDLE;
        end
        default: begin
          state_n = ST_IDLE;
        end
      endcase
    end
  end

  // Serial-input mux and mode-dependent seed
  always_comb begin
    ser_x = 1'b0;
    unique case (mode_q)
      MODE_RING:    ser_x = out[WIDTH-1];
      MODE_JOHNSON: ser_x = ~out[WIDTH-1];
      MODE_FILL:    ser_x = 1'b1;
      MODE_EXT:     ser_x = ext_x;
      default:      ser_x = 1'b0;
    endcase
  end

  assign seed = ((mode_q == MODE_RING) || (mode_q == MODE_EXT)) ? MSB_ONE : '0;

  // Decoded from the state register and stop so an aborted edge shows no pulse
  assign shift_pulse = shift_en;

  shift_reg_ld #(
    .WIDTH   (WIDTH),
    .RST_VAL (MSB_ONE)
  ) u_shift_reg (
    .cp       (cp),
    .reset    (reset),
    .load     (load_en),
    .shift_en (shift_en),
    .load_val (seed),
    .ser_in   (ser_x),
    .q        (out)
  );

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed self-checking bench for shift_seq_ctrl (WIDTH=4, CNT_W=4).
module tb_shift_seq_ctrl;

  logic       cp = 1'b0;
  logic       reset, start, stop, ext_x;
  logic [1:0] mode;
  logic [3:0] len, div;
  logic [3:0] out;
  logic       busy, done, shift_pulse;

  int errors = 0;
  int checks = 0;

`ifdef SHIFT_SEQ_PRESCALE_EN
  localparam int EXP_GAP  = 3;
  localparam int EXP_P0   = 3;
  localparam int EXP_DONE = 10;
`else
  localparam int EXP_GAP  = 1;
  localparam int EXP_P0   = 1;
  localparam int EXP_DONE = 4;
`endif

  logic [3:0] jexp [9] = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h0};

  always #5 cp = ~cp;

  shift_seq_ctrl dut (
    .cp          (cp),
    .reset       (reset),
    .start       (start),
    .stop        (stop),
    .mode        (mode),
    .len         (len),
    .div         (div),
    .ext_x       (ext_x),
    .out         (out),
    .busy        (busy),
    .done        (done),
    .shift_pulse (shift_pulse)
  );

  task automatic tick;
    @(posedge cp);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  initial begin
    int np, done_at;
    int p [3];

    reset = 1'b1; start = 1'b0; stop = 1'b0; ext_x = 1'b0;
    mode = 2'd0; len = 4'd0; div = 4'd0;
    tick; tick;
    chk("rst_out", 32'(out), 32'h8);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_sp", 32'(shift_pulse), 32'h0);
    reset = 1'b0;
    tick;
    chk("idle_busy", 32'(busy), 32'h0);

    // Ring, len=4; start/mode/len/div changes mid-run must be ignored
    mode = 2'd0; len = 4'd4; div = 4'd0; start = 1'b1;
    tick; start = 1'b0;
    chk("ring_load_busy", 32'(busy), 32'h1);
    chk("ring_load_out", 32'(out), 32'h8);
    tick;
    chk("ring_seed", 32'(out), 32'h8);
    chk("ring_sp0", 32'(shift_pulse), 32'h1);
    tick;
    chk("ring_s1", 32'(out), 32'h1);
    start = 1'b1; mode = 2'd1; len = 4'd1; div = 4'd3;
    tick; start = 1'b0;
    chk("ring_s2", 32'(out), 32'h2);
    chk("ring_s2_done", 32'(done), 32'h0);
    tick;
    chk("ring_s3", 32'(out), 32'h4);
    chk("ring_s3_sp", 32'(shift_pulse), 32'h1);
    tick;
    chk("ring_s4", 32'(out), 32'h8);
    chk("ring_done", 32'(done), 32'h1);
    chk("ring_done_sp", 32'(shift_pulse), 32'h0);
    chk("ring_done_busy", 32'(busy), 32'h1);
    tick;
    chk("ring_after_done", 32'(done), 32'h0);
    chk("ring_after_busy", 32'(busy), 32'h0);
    chk("ring_after_out", 32'(out), 32'h8);
    tick;
    chk("ring_no_restart", 32'(busy), 32'h0);

    // Johnson, len=8
    mode = 2'd1; len = 4'd8; div = 4'd0; start = 1'b1;
    tick; start = 1'b0;
    np = 0;
    for (int i = 0; i < 9; i++) begin
      tick;
      chk($sformatf("john_%0d", i), 32'(out), 32'(jexp[i]));
      if (shift_pulse) np++;
    end
    chk("john_pulses", 32'(np), 32'd8);
    chk("john_done", 32'(done), 32'h1);
    tick;

    // Fill-ones with prescale request (div=2)
    mode = 2'd2; len = 4'd3; div = 4'd2; start = 1'b1;
    tick; start = 1'b0;
    np = 0; done_at = 0;
    for (int i = 1; i <= 20; i++) begin
      tick;
      if (shift_pulse) begin
        if (np < 3) p[np] = i;
        np++;
      end
      if (done) begin
        done_at = i;
        break;
      end
    end
    chk("pre_done_at", 32'(done_at), 32'(EXP_DONE));
    chk("pre_pulses", 32'(np), 32'd3);
    if (np >= 3) begin
      chk("pre_first", 32'(p[0]), 32'(EXP_P0));
      chk("pre_gap1", 32'(p[1] - p[0]), 32'(EXP_GAP));
      chk("pre_gap2", 32'(p[2] - p[1]), 32'(EXP_GAP));
    end
    chk("pre_final", 32'(out), 32'h7);
    tick;

    // Abort after the 3rd shift of a ring run, len=10
    mode = 2'd0; len = 4'd10; div = 4'd0; start = 1'b1;
    tick; start = 1'b0;
    tick; tick; tick; tick;
    chk("abort_out3", 32'(out), 32'h4);
    stop = 1'b1;
    #1;
    chk("abort_sp_masked", 32'(shift_pulse), 32'h0);
    tick; stop = 1'b0;
    chk("abort_out", 32'(out), 32'h4);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_done", 32'(done), 32'h0);
    tick;
    chk("abort_done2", 32'(done), 32'h0);
    chk("abort_hold", 32'(out), 32'h4);

    // len=0: seed loaded, done on the following cycle
    mode = 2'd1; len = 4'd0; start = 1'b1;
    tick; start = 1'b0;
    chk("len0_hold", 32'(out), 32'h4);
    chk("len0_wait_done", 32'(done), 32'h0);
    tick;
    chk("len0_done", 32'(done), 32'h1);
    chk("len0_seed", 32'(out), 32'h0);
    tick;
    chk("len0_idle", 32'(busy), 32'h0);

    // External serial, len=4, bits 1,0,1,1
    mode = 2'd3; len = 4'd4; start = 1'b1;
    tick; start = 1'b0;
    tick;
    chk("ext_seed", 32'(out), 32'h8);
    ext_x = 1'b1; tick;
    chk("ext_s1", 32'(out), 32'h1);
    ext_x = 1'b0; tick;
    chk("ext_s2", 32'(out), 32'h2);
    ext_x = 1'b1; tick;
    chk("ext_s3", 32'(out), 32'h5);
    ext_x = 1'b1; tick;
    chk("ext_s4", 32'(out), 32'hB);
    chk("ext_done", 32'(done), 32'h1);
    ext_x = 1'b0;
    tick;

    // stop wins over SHIFT->DONE on the final shift edge
    mode = 2'd0; len = 4'd2; start = 1'b1;
    tick; start = 1'b0;
    tick; tick;
    chk("prio_out1", 32'(out), 32'h1);
    stop = 1'b1;
    tick; stop = 1'b0;
    chk("prio_out", 32'(out), 32'h1);
    chk("prio_done", 32'(done), 32'h0);
    chk("prio_busy", 32'(busy), 32'h0);
    tick;
    chk("prio_done2", 32'(done), 32'h0);

    // Reset mid-run overrides everything, including a held start
    mode = 2'd1; len = 4'd8; start = 1'b1;
    tick; start = 1'b0;
    tick; tick; tick;
    chk("mid_out", 32'(out), 32'h3);
    reset = 1'b1; start = 1'b1;
    tick;
    chk("mrst_out", 32'(out), 32'h8);
    chk("mrst_busy", 32'(busy), 32'h0);
    chk("mrst_done", 32'(done), 32'h0);
    chk("mrst_sp", 32'(shift_pulse), 32'h0);
    reset = 1'b0; start = 1'b0;
    tick;
    chk("mrst_idle", 32'(busy), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
